// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the MEM-stage data memory.
// Size encodings, FSM state type and access-width helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [3:0] size_bytes(
    input logic [1:0] sz
  );
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: shifts the selected lane of a word to bit 0 and
// zero/sign-extends it. In: word_i, off_i, size_i, unsigned_i. Out: data_o.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFFW   = 2
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [OFFW-1:0]   off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0]        lane;
  logic [DATA_W-1:0]        up;
  logic signed [DATA_W-1:0] sx;
  logic [6:0]               shamt;

  // Move the field to the top, then shift back down logically or
  // arithmetically; this covers every width without replication.
  always_comb begin
    lane  = word_i >> {off_i, 3'b000};
    shamt = 7'd0;
    unique case (1'b1)
      size_i == SZ_BYTE: shamt = 7'(DATA_W - 8);
      size_i == SZ_HALF: shamt = 7'(DATA_W - 16);
      size_i == SZ_WORD: shamt = 7'(DATA_W - 32);
      default:           shamt = 7'd0;
    endcase
    up     = lane << shamt;
    sx     = $signed(up) >>> shamt;
    data_o = unsigned_i ? (up >> shamt) : sx;
  end

endmodule

// File: rtl/dmem_pipelined.sv
// dmem_pipelined: handshaked byte-addressed data memory, fixed LATENCY.
// Ports: clk_i, rst_n_i, req_* (valid/ready request), resp_* (response
// pulse, data, error). Option: DMEM_MISALIGN_TRAP_EN traps misalignment.
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [31:0]       req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic              ready_q;
  logic              valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] cap_data_q;
  logic              cap_err_q;

  logic              acc;
  logic [31:0]       word_idx;
  logic [IDXW-1:0]   idx;
  logic [OFFW-1:0]   off;
  logic [OFFW-1:0]   off_al;
  logic [OFFW-1:0]   wm1;
  logic [3:0]        width;
  logic              oor;
  logic              bad_sz;
  logic              mis;
  logic              err;
  logic [BYTES-1:0]  be;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] live_data;

  assign acc      = req_valid_i & ready_q;
  assign word_idx = req_addr_i >> OFFW;
  assign idx      = word_idx[IDXW-1:0];
  assign off      = req_addr_i[OFFW-1:0];
  assign width    = size_bytes(req_size_i);
  assign wm1      = OFFW'(width - 4'd1);
  assign oor      = word_idx >= 32'(DEPTH);
  assign bad_sz   = (req_size_i == SZ_DOUBLE) && (DATA_W == 32);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis    = |(off & wm1);
  assign off_al = off;
`else
  assign mis    = 1'b0;
  assign off_al = off & ~wm1;
`endif

  assign err = oor | bad_sz | mis;

  assign be = BYTES'(((16'd1 << width) - 16'd1) << off_al);
  assign wdata_sh = req_wdata_i << {off_al, 3'b000};

  assign rd_word = mem_q[idx];

  dmem_load_align #(
    .DATA_W (DATA_W),
    .OFFW   (OFFW)
  ) u_align (
    .word_i     (rd_word),
    .off_i      (off_al),
    .size_i     (req_size_i),
    .unsigned_i (req_unsigned_i),
    .data_o     (aligned)
  );

  assign live_data = (err | req_write_i) ? '0 : aligned;

  // Not reset: contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (acc && req_write_i && !err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  // Load result is formed on the accept edge; with LATENCY>1 it waits
  // in the capture register until the response cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cap_data_q <= '0;
      cap_err_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_RESP: begin
          if (acc) begin
            if (LATENCY == 1) begin
              state_q <= S_RESP;
              valid_q <= 1'b1;
              rdata_q <= live_data;
              err_q   <= err;
            end else begin
              state_q    <= S_WAIT;
              cnt_q      <= 3'(LATENCY - 2);
              ready_q    <= 1'b0;
              cap_data_q <= live_data;
              cap_err_q  <= err;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q <= S_RESP;
            valid_q <= 1'b1;
            rdata_q <= cap_data_q;
            err_q   <= cap_err_q;
          end else begin
            cnt_q   <= cnt_q - 3'd1;
            ready_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_pipelined.sv
// tb_dmem_pipelined: checks dmem_pipelined (LATENCY 1 and 3 instances)
// against a byte-array model with a per-cycle response scoreboard.
module tb_dmem_pipelined;

  localparam int DEP = 1024;

  logic        clk = 1'b0;
  logic        rst1_n, rst3_n;
  logic        valid1, valid3;
  logic        write;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] wdata;
  logic        rdy1, val1, err1;
  logic        rdy3, val3, err3;
  logic [31:0] rd1, rd3;

  typedef struct {
    int          due;
    logic [31:0] d;
    bit          e;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [7:0]  m1[int];
  logic [7:0]  m3[int];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          last_acc3 = -100;
  bit          on1 = 0, on3 = 0;
  logic [31:0] last_d1 = '0, last_d3 = '0;
  bit          last_e1 = 0, last_e3 = 0;

  dmem_pipelined #(
    .DATA_W (32), .DEPTH (DEP), .LATENCY (1)
  ) u_dut1 (
    .clk_i          (clk),
    .rst_n_i        (rst1_n),
    .req_valid_i    (valid1),
    .req_ready_o    (rdy1),
    .req_write_i    (write),
    .req_addr_i     (addr),
    .req_size_i     (size),
    .req_unsigned_i (uns),
    .req_wdata_i    (wdata),
    .resp_valid_o   (val1),
    .resp_rdata_o   (rd1),
    .resp_err_o     (err1)
  );

  dmem_pipelined #(
    .DATA_W (32), .DEPTH (DEP), .LATENCY (3)
  ) u_dut3 (
    .clk_i          (clk),
    .rst_n_i        (rst3_n),
    .req_valid_i    (valid3),
    .req_ready_o    (rdy3),
    .req_write_i    (write),
    .req_addr_i     (addr),
    .req_size_i     (size),
    .req_unsigned_i (uns),
    .req_wdata_i    (wdata),
    .resp_valid_o   (val3),
    .resp_rdata_o   (rd3),
    .resp_err_o     (err3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Byte-array model: little-endian bytes, extend from the access width.
  task automatic model(input int inst, input bit w, input logic [31:0] a,
                       input logic [1:0] s, input bit u,
                       input logic [31:0] wd,
                       output logic [31:0] d, output bit e);
    int nb;
    int base;
    logic [63:0] v;
    nb   = 1 << s;
    base = int'(a);
    d    = '0;
    v    = '0;
    e    = ((a / 4) >= DEP) || (s == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((base % nb) != 0) e = 1;
`else
    base = base - (base % nb);
`endif
    if (e) return;
    if (w) begin
      for (int i = 0; i < nb; i++) begin
        if (inst == 1) m1[base+i] = wd[8*i +: 8];
        else           m3[base+i] = wd[8*i +: 8];
      end
    end else begin
      for (int i = 0; i < nb; i++)
        v[8*i +: 8] = (inst == 1) ? m1[base+i] : m3[base+i];
      if (!u && v[8*nb-1])
        for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
      d = v[31:0];
    end
  endtask

  // Entered and left on a negedge; request fields held until accepted.
  task automatic issue(input int inst, input bit w, input logic [31:0] a,
                       input logic [1:0] s, input bit u,
                       input logic [31:0] wd);
    exp_t x;
    int   n = 0;
    write = w; addr = a; size = s; uns = u; wdata = wd;
    if (inst == 1) valid1 = 1'b1;
    else           valid3 = 1'b1;
    while (((inst == 1) ? rdy1 : rdy3) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst=%0d addr=%h", inst, a);
    end else begin
      model(inst, w, a, s, u, wd, x.d, x.e);
      x.due = cyc + ((inst == 1) ? 1 : 3);
      if (inst == 1) q1.push_back(x);
      else begin
        q3.push_back(x);
        last_acc3 = cyc + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid1 = 1'b0;
    valid3 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    bit   ev;
    exp_t x;
    if (rst1_n) begin
      ev = (q1.size() > 0) && (q1[0].due == cyc);
      chk("resp_valid1", 32'(val1), 32'(ev));
      if (ev) begin
        x = q1.pop_front();
        chk("rdata1", rd1, x.d);
        chk("err1", 32'(err1), 32'(x.e));
        last_d1 = rd1;
        last_e1 = err1;
      end
      if (on1) chk("ready1", 32'(rdy1), 32'd1);
    end
    if (rst3_n) begin
      ev = (q3.size() > 0) && (q3[0].due == cyc);
      chk("resp_valid3", 32'(val3), 32'(ev));
      if (ev) begin
        x = q3.pop_front();
        chk("rdata3", rd3, x.d);
        chk("err3", 32'(err3), 32'(x.e));
        last_d3 = rd3;
        last_e3 = err3;
      end
      if (on3)
        chk("ready3", 32'(rdy3),
            32'(!(cyc >= last_acc3 && cyc <= last_acc3 + 1)));
    end
  end

  initial begin
    rst1_n = 0; rst3_n = 0;
    valid1 = 0; valid3 = 0;
    write = 0; addr = '0; size = '0; uns = 0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready1", 32'(rdy1), 32'd0);
    chk("rst_valid1", 32'(val1), 32'd0);
    chk("rst_rdata1", rd1, 32'd0);
    chk("rst_err1", 32'(err1), 32'd0);
    chk("rst_ready3", 32'(rdy3), 32'd0);
    rst1_n = 1; rst3_n = 1;
    #1;
    chk("rel_ready1_pre", 32'(rdy1), 32'd0);
    @(negedge clk);
    chk("rel_ready1_post", 32'(rdy1), 32'd1);
    chk("rel_ready3_post", 32'(rdy3), 32'd1);
    chk("rel_valid1", 32'(val1), 32'd0);
    on1 = 1; on3 = 1;

    issue(1, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF);
    issue(1, 1, 32'h11, 2'd0, 0, 32'h00000055);
    issue(1, 0, 32'h10, 2'd2, 0, 32'h0);
    idle(1);
    chk("lit_word_merge", last_d1, 32'hDEAD55EF);
    chk("lit_word_err", 32'(last_e1), 32'd0);
    issue(1, 0, 32'h13, 2'd0, 0, 32'h0);
    idle(1);
    chk("lit_sbyte", last_d1, 32'hFFFFFFDE);
    issue(1, 0, 32'h13, 2'd0, 1, 32'h0);
    idle(1);
    chk("lit_ubyte", last_d1, 32'h000000DE);
    issue(1, 0, 32'h12, 2'd1, 0, 32'h0);
    idle(1);
    chk("lit_shalf", last_d1, 32'hFFFFDEAD);

    issue(1, 1, 32'h20, 2'd2, 0, 32'h11223344);
    issue(1, 1, 32'h21, 2'd1, 0, 32'h0000ABCD);
    idle(1);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lit_mis_err", 32'(last_e1), 32'd1);
`else
    chk("lit_mis_err", 32'(last_e1), 32'd0);
`endif
    issue(1, 0, 32'h20, 2'd2, 0, 32'h0);
    issue(1, 0, 32'h22, 2'd1, 1, 32'h0);
    issue(1, 0, 32'h11, 2'd2, 0, 32'h0);
    idle(1);
    issue(1, 0, 32'h20, 2'd2, 0, 32'h0);
    idle(1);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lit_mis_mem", last_d1, 32'h11223344);
`else
    chk("lit_mis_mem", last_d1, 32'h1122ABCD);
`endif

    issue(1, 1, 32'h0, 2'd2, 0, 32'h01020304);
    issue(1, 1, 32'h1000, 2'd2, 0, 32'hFFFFFFFF);
    issue(1, 0, 32'h1000, 2'd2, 0, 32'h0);
    idle(1);
    chk("lit_oor_err", 32'(last_e1), 32'd1);
    chk("lit_oor_data", last_d1, 32'd0);
    issue(1, 0, 32'h0, 2'd2, 0, 32'h0);
    issue(1, 0, 32'h10, 2'd3, 0, 32'h0);
    idle(1);
    chk("lit_double_err", 32'(last_e1), 32'd1);
    issue(1, 0, 32'h0, 2'd2, 0, 32'h0);
    idle(1);
    chk("lit_oor_nowrite", last_d1, 32'h01020304);

    issue(3, 1, 32'h40, 2'd2, 0, 32'hCAFEF00D);
    issue(3, 0, 32'h40, 2'd2, 0, 32'h0);
    issue(3, 0, 32'h41, 2'd0, 1, 32'h0);
    issue(3, 0, 32'h42, 2'd1, 0, 32'h0);
    idle(3);
    chk("lit_l3_shalf", last_d3, 32'hFFFFCAFE);

    issue(3, 0, 32'h40, 2'd2, 0, 32'h0);
    rst3_n = 0;
    valid3 = 0;
    q3.delete();
    last_acc3 = -100;
    on3 = 0;
    repeat (3) @(negedge clk);
    rst3_n = 1;
    @(negedge clk);
    on3 = 1;
    repeat (5) @(negedge clk);
    issue(3, 0, 32'h40, 2'd2, 0, 32'h0);
    idle(3);
    chk("lit_l3_after_rst", last_d3, 32'hCAFEF00D);

    idle(5);
    chk("drain_q1", q1.size(), 32'd0);
    chk("drain_q3", q3.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
